// File: rtl/compare_arbiter_pkg.sv
// Shared definitions for the compare arbiter slice.
//   - Opcode encodings for the less-than compare (signed / unsigned).
//   - Result constants returned to requesters.
//   - FSM state type (IDLE, RESP) and 1-bit port index type.
//   - cmp_eval(): the shared less-than datapath.
package cmp_pkg;

  localparam logic [1:0]  CMP_SIGNED            = 2'b00;
  localparam logic [1:0]  CMP_UNSIGNED          = 2'b01;

  localparam logic [31:0] LT_RESULT             = 32'h1;
  localparam logic [31:0] GE_RESULT             = 32'h0;
  localparam logic [31:0] UNKNOWN_OPCODE_RESULT = 32'h0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_e;

  typedef logic port_idx_t;

  // Signed compare reuses the subtractor: when the signs differ the
  // difference can overflow, so the sign of op_a decides directly.
  function automatic logic [31:0] cmp_eval(input logic [1:0]  opcode,
                                           input logic [31:0] op_a,
                                           input logic [31:0] op_b);
    logic [31:0] diff;
    logic        lt;
    diff = op_a - op_b;
    lt   = 1'b0;
    cmp_eval = UNKNOWN_OPCODE_RESULT;
    case (opcode)
      CMP_SIGNED: begin
        lt = (op_a[31] != op_b[31]) ? op_a[31] : diff[31];
        cmp_eval = lt ? LT_RESULT : GE_RESULT;
      end
      CMP_UNSIGNED: begin
        lt = (op_a < op_b);
        cmp_eval = lt ? LT_RESULT : GE_RESULT;
      end
      default: cmp_eval = UNKNOWN_OPCODE_RESULT;
    endcase
  endfunction

endpackage

// File: rtl/compare_arbiter_rr_pick.sv
// Two-input grant picker for the compare arbiter.
// Configuration macro: COMPARE_ARBITER_RR_EN
//   defined   : round-robin; pointer flop advances to the port after the
//               one accepted whenever upd_i is high.
//   undefined : fixed priority, port 0 wins; no state is kept.
// Ports:
//   clk_i, rst_n_i : clock / async active-low reset (pointer only)
//   valid_i[1:0]   : request valids, bit N = port N
//   upd_i          : a grant was accepted this cycle
//   grant_o[1:0]   : one-hot grant (zero when nothing is valid)
//   grant_idx_o    : index of the granted port
module cmp_rr_pick
  import cmp_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [1:0] valid_i,
  input  logic       upd_i,
  output logic [1:0] grant_o,
  output port_idx_t  grant_idx_o
);

`ifdef COMPARE_ARBITER_RR_EN
  port_idx_t ptr_q, ptr_d;

  always_comb begin
    // The pointed-to port wins if it asks; otherwise the other one.
    grant_idx_o = valid_i[ptr_q] ? ptr_q : ~ptr_q;
    ptr_d       = ptr_q;
    if (upd_i) ptr_d = ~grant_idx_o;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) ptr_q <= 1'b0;
    else          ptr_q <= ptr_d;
  end
`else
  logic unused_ok;
  assign unused_ok = &{1'b0, clk_i, rst_n_i, upd_i};

  always_comb begin
    grant_idx_o = valid_i[0] ? 1'b0 : 1'b1;
  end
`endif

  always_comb begin
    grant_o    = 2'b00;
    grant_o[0] = valid_i[0] & (grant_idx_o == 1'b0);
    grant_o[1] = valid_i[1] & (grant_idx_o == 1'b1);
  end

endmodule

// File: rtl/compare_arbiter.sv
// Shares one signed/unsigned less-than compare between two requesters
// (port 0: EX-stage SLT family, port 1: branch resolve). One request is
// granted at a time, the result is registered and returned to its owner.
// Configuration macro: COMPARE_ARBITER_RR_EN (round-robin vs fixed priority).
// Ports:
//   clk_i, rst_n_i             : clock, async active-low reset
//   reqN_valid_i/reqN_ready_o  : request channel, port N
//   reqN_op_a_i, reqN_op_b_i   : operands
//   reqN_opcode_i              : 00 signed, 01 unsigned, others unknown
//   rspN_valid_o/rspN_ready_i  : response channel, port N
//   rspN_result_o              : result, zero unless rspN_valid_o
//   busy_o                     : result pending (FSM in RESP)
//
// Handshake: a transfer happens on a rising edge where valid & ready are
// both 1. Requesters hold valid and payload until the transfer. Request
// ready depends on the other valids (grant) and on the owner's response
// ready, so a response handshake and a new accept can share one edge.
module compare_arbiter
  import cmp_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req0_valid_i,
  output logic        req0_ready_o,
  input  logic [31:0] req0_op_a_i,
  input  logic [31:0] req0_op_b_i,
  input  logic [1:0]  req0_opcode_i,
  input  logic        req1_valid_i,
  output logic        req1_ready_o,
  input  logic [31:0] req1_op_a_i,
  input  logic [31:0] req1_op_b_i,
  input  logic [1:0]  req1_opcode_i,
  output logic        rsp0_valid_o,
  input  logic        rsp0_ready_i,
  output logic [31:0] rsp0_result_o,
  output logic        rsp1_valid_o,
  input  logic        rsp1_ready_i,
  output logic [31:0] rsp1_result_o,
  output logic        busy_o
);

  state_e      state_q, state_d;
  port_idx_t   own_q, own_d;
  logic [31:0] result_q, result_d;

  logic [1:0]  grant;
  port_idx_t   grant_idx;
  logic        rsp_hs, can_accept, accept;
  logic [31:0] sel_a, sel_b;
  logic [1:0]  sel_op;

  cmp_rr_pick u_pick (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .valid_i     ({req1_valid_i, req0_valid_i}),
    .upd_i       (accept),
    .grant_o     (grant),
    .grant_idx_o (grant_idx)
  );

  always_comb begin
    rsp_hs     = (state_q == ST_RESP) &&
                 ((own_q == 1'b1) ? rsp1_ready_i : rsp0_ready_i);
    can_accept = (state_q == ST_IDLE) || rsp_hs;
    accept     = can_accept && (grant != 2'b00);

    req0_ready_o = can_accept & grant[0];
    req1_ready_o = can_accept & grant[1];

    sel_a  = (grant_idx == 1'b1) ? req1_op_a_i   : req0_op_a_i;
    sel_b  = (grant_idx == 1'b1) ? req1_op_b_i   : req0_op_b_i;
    sel_op = (grant_idx == 1'b1) ? req1_opcode_i : req0_opcode_i;

    state_d  = state_q;
    own_d    = own_q;
    result_d = result_q;
    if (accept) begin
      state_d  = ST_RESP;
      own_d    = grant_idx;
      result_d = cmp_eval(sel_op, sel_a, sel_b);
    end else if (rsp_hs) begin
      state_d = ST_IDLE;
    end

    busy_o        = (state_q == ST_RESP);
    rsp0_valid_o  = busy_o && (own_q == 1'b0);
    rsp1_valid_o  = busy_o && (own_q == 1'b1);
    rsp0_result_o = rsp0_valid_o ? result_q : 32'h0;
    rsp1_result_o = rsp1_valid_o ? result_q : 32'h0;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_IDLE;
      own_q    <= 1'b0;
      result_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      own_q    <= own_d;
      result_q <= result_d;
    end
  end

endmodule
